// File: rtl/cla_pipe_adder_if.sv
// Handshake and data bundle for the pipelined carry-lookahead adder.
// The master drives operands and out_ready; the slave returns the result side.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic [WIDTH-1:0] carry;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, carry
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, carry
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// Stage 1 holds bit and group propagate/generate; stage 2 holds carries and sum.
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned GROUP = 4
) (
  input logic              clk,
  input logic              rst,
  cla_pipe_adder_if.slave  bus
);

  localparam int unsigned NG = WIDTH / GROUP;

  if (GROUP < 1 || GROUP > 8 || WIDTH < 2 || (WIDTH % GROUP) != 0) begin : g_param_err
    $error("cla_pipe_adder: WIDTH must be >= 2 and a multiple of GROUP, GROUP in 1..8");
  end

  // Sum-of-products lookahead: carry into position n of a propagate/generate
  // chain fed by c0. Every term is a flat AND, so no carry ripples.
  function automatic logic la_carry(logic [WIDTH-1:0] pv, logic [WIDTH-1:0] gv, logic c0,
                                    int unsigned n);
    logic r;
    logic t;
    r = c0;
    for (int unsigned m = 0; m < n; m++) r &= pv[m];
    for (int unsigned k = 0; k < n; k++) begin
      t = gv[k];
      for (int unsigned m = k + 1; m < n; m++) t &= pv[m];
      r |= t;
    end
    return r;
  endfunction

  logic             accept, s1_load, s2_load;
  logic [WIDTH-1:0] b_eff, p_c, g_c;
  logic [NG-1:0]    pg_c, gg_c;
  logic [WIDTH-1:0] p_d, p_q, g_d, g_q;
  logic [NG-1:0]    pg_d, pg_q, gg_d, gg_q;
  logic             c0_d, c0_q;
  logic             s1_valid_d, s1_valid_q;
  logic [NG-1:0]    gc;
  logic [WIDTH-1:0] carry_c, sum_c;
  logic [WIDTH-1:0] carry_d, carry_q, sum_d, sum_q;
  logic             s2_valid_d, s2_valid_q;

  always_comb begin : flow_comb
    s2_load = !s2_valid_q || bus.out_ready;
    s1_load = !s1_valid_q || s2_load;
    accept  = bus.in_valid && s1_load;
  end

  always_comb begin : stage1_comb
    b_eff = bus.b ^ {WIDTH{bus.sub}};
    p_c   = bus.a ^ b_eff;
    g_c   = bus.a & b_eff;
    pg_c  = '0;
    gg_c  = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      pg_c[j] = &p_c[j*GROUP +: GROUP];
      gg_c[j] = la_carry(WIDTH'(p_c[j*GROUP +: GROUP]), WIDTH'(g_c[j*GROUP +: GROUP]), 1'b0,
                         GROUP);
    end
    s1_valid_d = s1_load ? accept : s1_valid_q;
    p_d        = accept ? p_c : p_q;
    g_d        = accept ? g_c : g_q;
    pg_d       = accept ? pg_c : pg_q;
    gg_d       = accept ? gg_c : gg_q;
    c0_d       = accept ? (bus.cin ^ bus.sub) : c0_q;
  end

  always_comb begin : stage2_comb
    gc      = '0;
    carry_c = '0;
    for (int unsigned j = 0; j < NG; j++) begin
      gc[j] = la_carry(WIDTH'(pg_q), WIDTH'(gg_q), c0_q, j);
    end
    for (int unsigned j = 0; j < NG; j++) begin
      for (int unsigned k = 0; k < GROUP; k++) begin
        carry_c[j*GROUP+k] = la_carry(WIDTH'(p_q[j*GROUP +: GROUP]),
                                      WIDTH'(g_q[j*GROUP +: GROUP]), gc[j], k + 1);
      end
    end
    sum_c = p_q ^ {carry_c[WIDTH-2:0], c0_q};
    // Result registers only move when a real transaction advances; otherwise they hold.
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    carry_d    = (s2_load && s1_valid_q) ? carry_c : carry_q;
    sum_d      = (s2_load && s1_valid_q) ? sum_c : sum_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      pg_q       <= '0;
      gg_q       <= '0;
      c0_q       <= 1'b0;
      s2_valid_q <= 1'b0;
      carry_q    <= '0;
      sum_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      p_q        <= p_d;
      g_q        <= g_d;
      pg_q       <= pg_d;
      gg_q       <= gg_d;
      c0_q       <= c0_d;
      s2_valid_q <= s2_valid_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
    end
  end

  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.cout      = carry_q[WIDTH-1];
  assign bus.ovf       = carry_q[WIDTH-1] ^ carry_q[WIDTH-2];

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: directed cases on a 32/4 instance plus randomized
// streams on several width/group configurations against an arithmetic model.
module tb_cla_pipe_adder;

  typedef struct {
    logic [63:0] sum;
    logic [63:0] carry;
    logic        cout;
    logic        ovf;
  } res_t;

  localparam int WS [4] = '{8, 16, 32, 12};
  localparam int GS [4] = '{4, 8, 4, 1};
  localparam int NRAND  = 2500;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_r = 1'b1;
  int   n_total = 0;
  int   n_bad = 0;
  logic [3:0] cfg_done = '0;

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic res_t model(int w, logic [63:0] a_i, logic [63:0] b_i, logic cin,
                                 logic sub);
    res_t        r;
    logic [63:0] mask, a, b, bb, mi, part, full;
    longint      sa, sb, tr, lim;
    mask = (64'd1 << w) - 64'd1;
    a    = a_i & mask;
    b    = b_i & mask;
    full = sub ? a - b - 64'(cin) : a + b + 64'(cin);
    r.sum  = full & mask;
    r.cout = sub ? (a >= b + 64'(cin)) : full[w];
    bb = sub ? (~b & mask) : b;
    r.carry = '0;
    for (int i = 0; i < w; i++) begin
      mi   = (64'd1 << (i + 1)) - 64'd1;
      part = (a & mi) + (bb & mi) + 64'(cin ^ sub);
      r.carry[i] = part[i+1];
    end
    sa  = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb  = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    tr  = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
    lim = longint'(1) << (w - 1);
    r.ovf = (tr >= lim) || (tr < -lim);
    return r;
  endfunction

  function automatic logic [63:0] pick(int w);
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return (64'd1 << w) - 64'd1;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- directed 32/4 instance ----------------
  cla_pipe_adder_if #(.WIDTH(32)) dbus ();
  cla_pipe_adder #(.WIDTH(32), .GROUP(4)) u_dir (.clk(clk), .rst(rst_d), .bus(dbus));

  res_t        dq[$];
  logic        acc_f, cons_f;
  logic [31:0] ia [4];
  logic [31:0] ib [4];

  task automatic dir_cycle();
    res_t e;
    @(negedge clk);
    acc_f  = dbus.in_valid && dbus.in_ready;
    cons_f = dbus.out_valid && dbus.out_ready;
    if (acc_f && !rst_d) dq.push_back(model(32, 64'(dbus.a), 64'(dbus.b), dbus.cin, dbus.sub));
    if (cons_f && !rst_d) begin
      if (dq.size() == 0) check("dir_extra", 1, 0);
      else begin
        e = dq.pop_front();
        check("dir_sum", 64'(dbus.sum), e.sum);
        check("dir_carry", 64'(dbus.carry), e.carry);
        check("dir_cout", 64'(dbus.cout), 64'(e.cout));
        check("dir_ovf", 64'(dbus.ovf), 64'(e.ovf));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic one_op(logic [31:0] a, logic [31:0] b, logic cin, logic sub,
                        logic [31:0] es, logic ec, logic eo);
    dbus.a = a; dbus.b = b; dbus.cin = cin; dbus.sub = sub;
    dbus.in_valid = 1'b1; dbus.out_ready = 1'b1;
    dir_cycle();
    dbus.in_valid = 1'b0;
    check("lat_early", 64'(dbus.out_valid), 0);
    dir_cycle();
    check("lat_exact", 64'(dbus.out_valid), 1);
    check("op_sum", 64'(dbus.sum), 64'(es));
    check("op_cout", 64'(dbus.cout), 64'(ec));
    check("op_ovf", 64'(dbus.ovf), 64'(eo));
    dir_cycle();
    check("op_drop", 64'(dbus.out_valid), 0);
    check("op_hold", 64'(dbus.sum), 64'(es));
  endtask

  task automatic load_item(int k);
    dbus.a = ia[k]; dbus.b = ib[k]; dbus.cin = k[0]; dbus.sub = k[1];
  endtask

  initial begin
    logic [31:0] held;
    int          k;
    int          wait_cyc;
    dbus.in_valid = 1'b0; dbus.out_ready = 1'b1;
    dbus.a = '0; dbus.b = '0; dbus.cin = 1'b0; dbus.sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_d = 1'b0;
    rst_r = 1'b0;
    check("rst_out_valid", 64'(dbus.out_valid), 0);
    check("rst_sum", 64'(dbus.sum), 0);
    check("rst_carry", 64'(dbus.carry), 0);
    check("rst_cout", 64'(dbus.cout), 0);
    check("rst_ovf", 64'(dbus.ovf), 0);
    check("rst_in_ready", 64'(dbus.in_ready), 1);

    one_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_carry", 64'(dbus.carry), 64'hFFFF_FFFF);
    one_op(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    one_op(32'd7, 32'd5, 1'b0, 1'b1, 32'd2, 1'b1, 1'b0);
    one_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    one_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: fill both stages, hold, then release.
    for (int i = 0; i < 4; i++) begin
      ia[i] = $urandom; ib[i] = $urandom;
    end
    k = 0;
    dbus.out_ready = 1'b0;
    load_item(0);
    dbus.in_valid = 1'b1;
    repeat (2) begin
      dir_cycle();
      if (acc_f) k++;
      load_item(k);
    end
    check("bp_accepts", 64'(k), 2);
    check("bp_in_ready", 64'(dbus.in_ready), 0);
    held = dbus.sum;
    repeat (4) begin
      dbus.a = $urandom; dbus.b = $urandom;
      dir_cycle();
      check("bp_stall_rdy", 64'(dbus.in_ready), 0);
      check("bp_stall_vld", 64'(dbus.out_valid), 1);
      check("bp_stall_sum", 64'(dbus.sum), 64'(held));
    end
    load_item(k);
    dbus.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      dir_cycle();
      check("bp_rate", 64'(cons_f), 1);
      if (acc_f) k++;
      if (k < 4) load_item(k);
      else dbus.in_valid = 1'b0;
    end
    check("bp_drain", 64'(dq.size()), 0);

    // Reset with two transactions in flight.
    dbus.out_ready = 1'b0;
    dbus.in_valid  = 1'b1;
    dbus.a = $urandom; dbus.b = $urandom;
    dir_cycle();
    dbus.a = $urandom;
    dir_cycle();
    dbus.in_valid = 1'b0;
    check("rst_pre_vld", 64'(dbus.out_valid), 1);
    rst_d = 1'b1;
    dir_cycle();
    check("rst_mid_vld", 64'(dbus.out_valid), 0);
    check("rst_mid_sum", 64'(dbus.sum), 0);
    dq.delete();
    rst_d = 1'b0;
    dbus.out_ready = 1'b1;
    repeat (5) begin
      dir_cycle();
      check("rst_quiet", 64'(dbus.out_valid), 0);
      check("rst_rdy", 64'(dbus.in_ready), 1);
    end

    wait_cyc = 0;
    while (cfg_done != 4'hF && wait_cyc < 60000) begin
      @(posedge clk);
      wait_cyc++;
    end
    check("cfg_timeout", 64'(cfg_done), 64'hF);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // ---------------- randomized configurations ----------------
  for (genvar ci = 0; ci < 4; ci++) begin : g_cfg
    localparam int W = WS[ci];
    localparam int G = GS[ci];

    cla_pipe_adder_if #(.WIDTH(W)) bus ();
    cla_pipe_adder #(.WIDTH(W), .GROUP(G)) u_dut (.clk(clk), .rst(rst_r), .bus(bus));

    res_t exp_q[$];

    initial begin
      int   issued, done, cyc;
      res_t e;
      issued = 0; done = 0; cyc = 0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      wait (rst_r == 1'b0);
      @(posedge clk);
      #1;
      while (done < NRAND && cyc < 40000) begin
        @(negedge clk);
        if (bus.in_valid && bus.in_ready) begin
          exp_q.push_back(model(W, 64'(bus.a), 64'(bus.b), bus.cin, bus.sub));
          issued++;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) check("rnd_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rnd_sum", 64'(bus.sum), e.sum);
            check("rnd_carry", 64'(bus.carry), e.carry);
            check("rnd_cout", 64'(bus.cout), 64'(e.cout));
            check("rnd_ovf", 64'(bus.ovf), 64'(e.ovf));
          end
          done++;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = (issued < NRAND) && ($urandom_range(3) != 0);
        bus.out_ready = ($urandom_range(3) != 0);
        bus.a   = W'(pick(W));
        bus.b   = W'(pick(W));
        bus.cin = 1'($urandom);
        bus.sub = 1'($urandom);
        cyc++;
      end
      check("rnd_count", 64'(done), 64'(NRAND));
      cfg_done[ci] = 1'b1;
    end
  end

endmodule
